// File: rtl/dac_serial_responder.sv
// Serialises one 24-bit DAC frame per dacdav/davdac 4-phase handshake; cs_n low 49*CLK_DIV cycles.
// First sclk rise CLK_DIV cycles after cs_n falls; a new frame waits until dacdav is seen low after davdac.
module dac_serial_responder #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dacdav,
   input  logic [1:0]  daccmd,
   input  logic [11:0] sample,
   output logic        davdac,
   output logic        busy,
   output logic        dac_cs_n,
   output logic        dac_sclk,
   output logic        dac_sdi
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_CS_HOLD,
      S_ACK
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t      r_state, w_state;
   logic [22:0] r_shift, w_shift;
   logic [4:0]  r_bitcnt, w_bitcnt;
   logic [7:0]  r_div, w_div;
   logic        r_cs_n, w_cs_n;
   logic        r_sclk, w_sclk;
   logic        r_sdi, w_sdi;
   logic        r_davdac, w_davdac;
   logic        r_busy, w_busy;
   logic [23:0] w_frame;

   assign w_frame = {2'b00, daccmd, 4'b0000, sample, 4'b0000};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_shift  <= '0;
         r_bitcnt <= '0;
         r_div    <= '0;
         r_cs_n   <= 1'b1;
         r_sclk   <= 1'b0;
         r_sdi    <= 1'b0;
         r_davdac <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_shift  <= w_shift;
         r_bitcnt <= w_bitcnt;
         r_div    <= w_div;
         r_cs_n   <= w_cs_n;
         r_sclk   <= w_sclk;
         r_sdi    <= w_sdi;
         r_davdac <= w_davdac;
         r_busy   <= w_busy;
      end
   end

   always_comb begin
      w_state  = r_state;
      w_shift  = r_shift;
      w_bitcnt = r_bitcnt;
      w_div    = r_div;
      w_cs_n   = r_cs_n;
      w_sclk   = r_sclk;
      w_sdi    = r_sdi;
      w_davdac = r_davdac;
      w_busy   = r_busy;
      case (r_state)
         S_IDLE: begin
            if (dacdav && !r_davdac) begin
               w_shift  = w_frame[22:0];
               w_sdi    = w_frame[23];
               w_cs_n   = 1'b0;
               w_sclk   = 1'b0;
               w_bitcnt = 5'd23;
               w_div    = '0;
               w_busy   = 1'b1;
               w_state  = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (r_div == DIV_LAST) begin
               w_div  = '0;
               w_sclk = ~r_sclk;
               // Data only moves on the falling sclk edge so the DAC samples a stable bit on the rise.
               if (r_sclk) begin
                  if (r_bitcnt != 5'd0) begin
                     w_sdi    = r_shift[22];
                     w_shift  = {r_shift[21:0], 1'b0};
                     w_bitcnt = r_bitcnt - 5'd1;
                  end else begin
                     w_sclk  = 1'b0;
                     w_sdi   = 1'b0;
                     w_state = S_CS_HOLD;
                  end
               end
            end else begin
               w_div = r_div + 8'd1;
            end
         end
         S_CS_HOLD: begin
            if (r_div == DIV_LAST) begin
               w_div    = '0;
               w_cs_n   = 1'b1;
               w_busy   = 1'b0;
               w_davdac = 1'b1;
               w_state  = S_ACK;
            end else begin
               w_div = r_div + 8'd1;
            end
         end
         S_ACK: begin
            if (!dacdav) begin
               w_davdac = 1'b0;
               w_state  = S_IDLE;
            end
         end
         default: w_state = S_IDLE;
      endcase
   end

   assign davdac   = r_davdac;
   assign busy     = r_busy;
   assign dac_cs_n = r_cs_n;
   assign dac_sclk = r_sclk;
   assign dac_sdi  = r_sdi;

endmodule
